vgpr_wr_port_arbiter: RTL and testbench

//  Schedules VGPR writeback onto the two write ports of the 64-page 1024x32b register file.
//  NUM_ALU requesters (SIMD/SIMF) share wr0, one per cycle, chosen round-robin.
//  The LSU owns wr1, which carries up to 4 consecutive dwords.
//  All port drives are registered. A request is accepted in cycle N and written at the RF in cycle N+1.

---
 rtl/vgpr_pkg.sv | 19 +
 rtl/vgpr_wr_port_arbiter_if.sv | 36 +++
 rtl/vgpr_rr_arb.sv | 35 +++
 rtl/vgpr_wr_port_arbiter.sv | 105 ++++++++++
 tb/tb_vgpr_wr_port_arbiter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/vgpr_pkg.sv
// vgpr_pkg: shared VGPR geometry constants, types and address helper
// Used by vgpr_wr_port_arbiter, its interface and vgpr_rr_arb.
package vgpr_pkg;
    localparam int VGPR_ADDR_W     = 10;
    localparam int VGPR_LANES      = 64;
    localparam int VGPR_DWORD_W    = 32;
    localparam int VGPR_MAX_DWORDS = 4;
    localparam int VGPR_ROW_W      = VGPR_LANES * VGPR_DWORD_W;

    typedef logic [VGPR_ADDR_W-1:0] vgpr_addr_t;
    typedef logic [VGPR_LANES-1:0]  vgpr_lane_mask_t;

    typedef enum logic {ALU_PRI, LSU_PRI} wr_pri_e;

    // Target of LSU dword k; the 10-bit sum wraps mod 1024.
    function automatic vgpr_addr_t lsu_dword_addr(input vgpr_addr_t base, input int k);
        return base + vgpr_addr_t'(k);
    endfunction
endpackage

// File: rtl/vgpr_wr_port_arbiter_if.sv
// vgpr_wr_port_arbiter_if: request handshakes and RF write-port bus
// master: requesters/RF side (drives *_req_*, receives ready and wr*)
// slave : arbiter side (receives *_req_*, drives ready and wr*)
interface vgpr_wr_port_arbiter_if import vgpr_pkg::*; #(parameter int NUM_ALU = 2);
    logic [NUM_ALU-1:0]                alu_req_valid;
    logic [NUM_ALU-1:0]                alu_req_ready;
    logic [VGPR_ADDR_W*NUM_ALU-1:0]    alu_req_addr;
    logic [VGPR_LANES*NUM_ALU-1:0]     alu_req_lane_en;
    logic [VGPR_ROW_W*NUM_ALU-1:0]     alu_req_data;
    logic                              lsu_req_valid;
    logic                              lsu_req_ready;
    vgpr_addr_t                        lsu_req_addr;
    vgpr_lane_mask_t                   lsu_req_lane_en;
    logic [VGPR_MAX_DWORDS-1:0]        lsu_req_dword_en;
    logic [VGPR_ROW_W*VGPR_MAX_DWORDS-1:0] lsu_req_data;
    vgpr_lane_mask_t                   wr0_en;
    vgpr_addr_t                        wr0_addr;
    logic [VGPR_ROW_W-1:0]             wr0_data;
    vgpr_lane_mask_t                   wr1_en;
    logic [VGPR_MAX_DWORDS-1:0]        wr1_en_xoutof4;
    vgpr_addr_t                        wr1_addr;
    logic [VGPR_ROW_W*VGPR_MAX_DWORDS-1:0] wr1_data;

    modport master (
        output alu_req_valid, alu_req_addr, alu_req_lane_en, alu_req_data,
        output lsu_req_valid, lsu_req_addr, lsu_req_lane_en, lsu_req_dword_en, lsu_req_data,
        input  alu_req_ready, lsu_req_ready,
        input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_en_xoutof4, wr1_addr, wr1_data
    );
    modport slave (
        input  alu_req_valid, alu_req_addr, alu_req_lane_en, alu_req_data,
        input  lsu_req_valid, lsu_req_addr, lsu_req_lane_en, lsu_req_dword_en, lsu_req_data,
        output alu_req_ready, lsu_req_ready,
        output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_en_xoutof4, wr1_addr, wr1_data
    );
endinterface

// File: rtl/vgpr_rr_arb.sv
// vgpr_rr_arb: N-way round-robin picker with hold
// Ports: clk, rst_n; req[N] in; hold in (suppresses pointer update);
//        pick[N] out, one-hot winner ignoring hold (caller masks it).
module vgpr_rr_arb #(parameter int N = 2) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         hold,
    output logic [N-1:0] pick
);
    localparam int PW = $clog2(N);
    logic [PW-1:0] ptr_q, ptr_d, nxt;
    logic          found;
    int            j;
    // ptr_q is the first requester searched, i.e. last winner + 1.
    always_comb begin
        pick  = '0;
        nxt   = ptr_q;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found   = 1'b1;
                pick[j] = 1'b1;
                nxt     = (j == N - 1) ? '0 : PW'(j + 1);
            end
        end
        ptr_d = hold ? ptr_q : nxt;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
endmodule

// File: rtl/vgpr_wr_port_arbiter.sv
// vgpr_wr_port_arbiter: schedules ALU (wr0, round-robin) and LSU (wr1) VGPR writeback
// Ports: clk, rst_n (async, active low); bus (vgpr_wr_port_arbiter_if.slave)
//        carrying request handshakes and registered RF wr0/wr1 drives.
// Optional: VGPR_WR_CONFLICT_CHECK_EN enables the ALU/LSU conflict FSM.
module vgpr_wr_port_arbiter import vgpr_pkg::*; #(parameter int NUM_ALU = 2) (
    input  logic                           clk,
    input  logic                           rst_n,
    vgpr_wr_port_arbiter_if.slave          bus
);
    logic [NUM_ALU-1:0]                    pick, gnt;
    logic                                  alu_hold, lsu_block, alu_go, lsu_go;
    vgpr_addr_t                            sel_addr;
    vgpr_lane_mask_t                       sel_lane;
    logic [VGPR_ROW_W-1:0]                 sel_data;
    vgpr_lane_mask_t                       wr0_en_q, wr0_en_d, wr1_en_q, wr1_en_d;
    vgpr_addr_t                            wr0_addr_q, wr0_addr_d, wr1_addr_q, wr1_addr_d;
    logic [VGPR_ROW_W-1:0]                 wr0_data_q, wr0_data_d;
    logic [VGPR_MAX_DWORDS-1:0]            wr1_x_q, wr1_x_d;
    logic [VGPR_ROW_W*VGPR_MAX_DWORDS-1:0] wr1_data_q, wr1_data_d;

    vgpr_rr_arb #(.N(NUM_ALU)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus.alu_req_valid),
        .hold  (alu_hold),
        .pick  (pick)
    );

    // pick is one-hot or zero, so an AND-OR mux selects the winner.
    always_comb begin
        sel_addr = '0;
        sel_lane = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_ALU; i++) begin
            sel_addr |= bus.alu_req_addr[VGPR_ADDR_W*i +: VGPR_ADDR_W] & {VGPR_ADDR_W{pick[i]}};
            sel_lane |= bus.alu_req_lane_en[VGPR_LANES*i +: VGPR_LANES] & {VGPR_LANES{pick[i]}};
            sel_data |= bus.alu_req_data[VGPR_ROW_W*i +: VGPR_ROW_W] & {VGPR_ROW_W{pick[i]}};
        end
    end

`ifdef VGPR_WR_CONFLICT_CHECK_EN
    wr_pri_e pri_q, pri_d;
    logic    conflict;
    // Conflicting side alternates so neither ALU nor LSU starves.
    always_comb begin
        conflict = 1'b0;
        for (int k = 0; k < VGPR_MAX_DWORDS; k++)
            conflict |= bus.lsu_req_dword_en[k] && (lsu_dword_addr(bus.lsu_req_addr, k) == sel_addr);
        conflict  = conflict && bus.lsu_req_valid && |pick && |(sel_lane & bus.lsu_req_lane_en);
        alu_hold  = conflict && pri_q == LSU_PRI;
        lsu_block = conflict && pri_q == ALU_PRI;
        pri_d     = conflict ? (pri_q == ALU_PRI ? LSU_PRI : ALU_PRI) : pri_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pri_q <= ALU_PRI;
        else        pri_q <= pri_d;
`else
    assign alu_hold  = 1'b0;
    assign lsu_block = 1'b0;
`endif

    assign gnt               = alu_hold ? '0 : pick;
    assign alu_go            = |gnt;
    assign lsu_go            = bus.lsu_req_valid && !lsu_block;
    assign bus.alu_req_ready = gnt;
    assign bus.lsu_req_ready = lsu_go;

    always_comb begin
        wr0_en_d   = alu_go ? sel_lane : '0;
        wr0_addr_d = alu_go ? sel_addr : '0;
        wr0_data_d = alu_go ? sel_data : '0;
        wr1_en_d   = lsu_go ? bus.lsu_req_lane_en  : '0;
        wr1_x_d    = lsu_go ? bus.lsu_req_dword_en : '0;
        wr1_addr_d = lsu_go ? bus.lsu_req_addr     : '0;
        wr1_data_d = lsu_go ? bus.lsu_req_data     : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr0_en_q   <= '0;
            wr0_addr_q <= '0;
            wr0_data_q <= '0;
            wr1_en_q   <= '0;
            wr1_x_q    <= '0;
            wr1_addr_q <= '0;
            wr1_data_q <= '0;
        end else begin
            wr0_en_q   <= wr0_en_d;
            wr0_addr_q <= wr0_addr_d;
            wr0_data_q <= wr0_data_d;
            wr1_en_q   <= wr1_en_d;
            wr1_x_q    <= wr1_x_d;
            wr1_addr_q <= wr1_addr_d;
            wr1_data_q <= wr1_data_d;
        end
    end

    assign bus.wr0_en         = wr0_en_q;
    assign bus.wr0_addr       = wr0_addr_q;
    assign bus.wr0_data       = wr0_data_q;
    assign bus.wr1_en         = wr1_en_q;
    assign bus.wr1_en_xoutof4 = wr1_x_q;
    assign bus.wr1_addr       = wr1_addr_q;
    assign bus.wr1_data       = wr1_data_q;
endmodule

// File: tb/tb_vgpr_wr_port_arbiter.sv
// tb_vgpr_wr_port_arbiter: directed scoreboard bench for vgpr_wr_port_arbiter
module tb_vgpr_wr_port_arbiter;
    import vgpr_pkg::*;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst_n;
    vgpr_wr_port_arbiter_if #(.NUM_ALU(N)) bus();
    vgpr_wr_port_arbiter #(.NUM_ALU(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        bit          v0;
        logic [63:0] e0;
        logic [9:0]  a0;
        logic [31:0] d0;
        bit          v1;
        logic [63:0] e1;
        logic [3:0]  x1;
        logic [9:0]  a1;
        logic [31:0] d1;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   total  = 0;
    int   m_ptr  = 0;
    bit   m_lsu_pri = 1'b0;
    int   wrap_exp[4] = '{1022, 1023, 0, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_alu(input int i, input bit v, input logic [9:0] a, input logic [63:0] l, input logic [31:0] w);
        bus.alu_req_valid[i]         = v;
        bus.alu_req_addr[10*i +: 10] = a;
        bus.alu_req_lane_en[64*i +: 64] = l;
        bus.alu_req_data[2048*i +: 2048] = {64{w}};
    endtask

    task automatic set_lsu(input bit v, input logic [9:0] a, input logic [63:0] l, input logic [3:0] d, input logic [31:0] w);
        bus.lsu_req_valid    = v;
        bus.lsu_req_addr     = a;
        bus.lsu_req_lane_en  = l;
        bus.lsu_req_dword_en = d;
        bus.lsu_req_data     = {256{w}};
    endtask

    // Called at posedge+1 with inputs applied: model the grant, check ready
    // before the edge, then check the registered writes after it.
    task automatic step(input string tag);
        exp_t        e;
        logic [N-1:0] er;
        int          pick;
        bit          conf, alu_ok, lsu_ok;
        pick = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (pick < 0 && bus.alu_req_valid[j]) pick = j;
        end
        conf = 1'b0;
`ifdef VGPR_WR_CONFLICT_CHECK_EN
        if (pick >= 0 && bus.lsu_req_valid && |(bus.alu_req_lane_en[64*pick +: 64] & bus.lsu_req_lane_en))
            for (int k = 0; k < 4; k++)
                if (bus.lsu_req_dword_en[k] && 10'(bus.lsu_req_addr + 10'(k)) == bus.alu_req_addr[10*pick +: 10])
                    conf = 1'b1;
`endif
        alu_ok = pick >= 0 && !(conf && m_lsu_pri);
        lsu_ok = bus.lsu_req_valid && !(conf && !m_lsu_pri);
        er = '0;
        e  = '{default: '0};
        if (alu_ok) begin
            er[pick] = 1'b1;
            e.v0 = 1'b1;
            e.e0 = bus.alu_req_lane_en[64*pick +: 64];
            e.a0 = bus.alu_req_addr[10*pick +: 10];
            e.d0 = bus.alu_req_data[2048*pick +: 32];
        end
        if (lsu_ok) begin
            e.v1 = 1'b1;
            e.e1 = bus.lsu_req_lane_en;
            e.x1 = bus.lsu_req_dword_en;
            e.a1 = bus.lsu_req_addr;
            e.d1 = bus.lsu_req_data[31:0];
        end
        sbq.push_back(e);
        #3;
        chk({tag, "/alu_ready"}, 64'(bus.alu_req_ready), 64'(er));
        chk({tag, "/lsu_ready"}, 64'(bus.lsu_req_ready), 64'(lsu_ok));
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({tag, "/wr0_en"}, bus.wr0_en, e.e0);
        chk({tag, "/wr1_en"}, bus.wr1_en, e.e1);
        chk({tag, "/wr1_x"}, 64'(bus.wr1_en_xoutof4), 64'(e.x1));
        if (e.v0) begin
            chk({tag, "/wr0_addr"}, 64'(bus.wr0_addr), 64'(e.a0));
            chk({tag, "/wr0_data"}, 64'(bus.wr0_data[31:0]), 64'(e.d0));
        end
        if (e.v1) begin
            chk({tag, "/wr1_addr"}, 64'(bus.wr1_addr), 64'(e.a1));
            chk({tag, "/wr1_data"}, 64'(bus.wr1_data[31:0]), 64'(e.d1));
        end
        if (alu_ok) m_ptr = (pick + 1) % N;
        if (conf) m_lsu_pri = !m_lsu_pri;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_alu(i, 0, '0, '0, '0);
        set_lsu(0, '0, '0, '0, '0);
        #2;
        chk("reset/wr0_en", bus.wr0_en, 64'h0);
        chk("reset/wr1_en", bus.wr1_en, 64'h0);
        chk("reset/wr1_x", 64'(bus.wr1_en_xoutof4), 64'h0);
        chk("reset/wr0_addr", 64'(bus.wr0_addr), 64'h0);
        chk("reset/wr1_addr", 64'(bus.wr1_addr), 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        set_alu(0, 1, 10'd100, '1, 32'hA000_0000);
        set_alu(1, 1, 10'd200, '1, 32'hA000_0001);
        for (int c = 0; c < 4; c++) step($sformatf("rr%0d", c));

        set_lsu(1, 10'd300, '1, 4'b0001, 32'hB000_0000);
        step("burst");
        rst_n = 1'b0;
        #1;
        chk("midrst/wr0_en", bus.wr0_en, 64'h0);
        chk("midrst/wr1_en", bus.wr1_en, 64'h0);
        chk("midrst/wr1_x", 64'(bus.wr1_en_xoutof4), 64'h0);
        sbq.delete();
        m_ptr = 0;
        m_lsu_pri = 1'b0;
        #1;
        rst_n = 1'b1;
        step("post_rst");
        set_alu(0, 0, '0, '0, '0);
        set_alu(1, 0, '0, '0, '0);

        set_lsu(1, 10'd1022, '1, 4'b1111, 32'hB000_0001);
        step("wrap");
        for (int k = 0; k < 4; k++)
            chk($sformatf("wrap/dword%0d", k), 64'(10'(bus.wr1_addr + 10'(k))), 64'(wrap_exp[k]));
        set_lsu(0, '0, '0, '0, '0);

        set_alu(1, 1, 10'd50, '0, 32'hA000_0002);
        step("zero_lane");
        set_alu(0, 1, 10'd60, '1, 32'hA000_0003);
        step("after_zero");
        set_alu(1, 0, '0, '0, '0);

        set_alu(0, 1, 10'd5, '1, 32'hC000_0000);
        set_lsu(1, 10'd4, '1, 4'b0010, 32'hD000_0000);
        for (int c = 0; c < 3; c++) step($sformatf("conflict%0d", c));

        set_alu(0, 1, 10'd5, 64'h0000_00FF, 32'hC000_0001);
        set_lsu(1, 10'd4, 64'h0000_FF00, 4'b0010, 32'hD000_0001);
        step("disjoint_lanes");

        set_alu(0, 1, 10'd10, '1, 32'hC000_0002);
        set_lsu(1, 10'd20, '1, 4'b0001, 32'hD000_0002);
        step("simul");

        set_alu(0, 0, '0, '0, '0);
        set_lsu(0, '0, '0, '0, '0);
        step("idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
